// File: rtl/regfile_ctrl_pkg.sv
// Shared encodings for the register-file command sequencer.
// Op codes and the one-hot sequencer state.
package regfile_ctrl_pkg;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_MOV  = 2'b01;
  localparam logic [1:0] OP_ADD  = 2'b10;
  localparam logic [1:0] OP_READ = 2'b11;

  typedef enum logic [4:0] {
    StIdle  = 5'b00001,
    StReadA = 5'b00010,
    StReadB = 5'b00100,
    StWrite = 5'b01000,
    StResp  = 5'b10000
  } state_e;

  typedef struct packed {
    logic [1:0]  op;
    logic [2:0]  rd;
    logic [2:0]  rs;
    logic [2:0]  rt;
    logic [15:0] imm;
  } cmd_t;

endpackage

// File: rtl/rfc_state_reg.sv
// Load-enable register with asynchronous active-high clear.
// Used for the command latch, operand capture and held port values.
module rfc_state_reg #(
  parameter int unsigned Width = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [Width-1:0] d,
  output logic [Width-1:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/regfile_ctrl.sv
// Sequencer that turns LOAD/MOV/ADD/READ commands into regfile port traffic.
// Port strobes decode the one-hot state so reset kills a pending write at once.
module regfile_ctrl
  import regfile_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [2:0]  cmd_rd,
  input  logic [2:0]  cmd_rs,
  input  logic [2:0]  cmd_rt,
  input  logic [15:0] cmd_imm,
  output logic [2:0]  rf_readnum,
  input  logic [15:0] rf_data_out,
  output logic [2:0]  rf_writenum,
  output logic        rf_write,
  output logic [15:0] rf_data_in,
  output logic        rsp_valid,
  output logic [15:0] rsp_data,
  output logic        done
);

  state_e      state_q;
  cmd_t        cmd_d, cmd_q;
  logic        accept;
  logic        in_read_a, in_read_b, in_write, in_resp;
  logic [15:0] a_q, b_q, wr_data;
  logic [2:0]  readnum_q;
  logic [18:0] wr_hold_q;
  logic [15:0] rsp_q;

  assign in_read_a = (state_q == StReadA);
  assign in_read_b = (state_q == StReadB);
  assign in_write  = (state_q == StWrite);
  assign in_resp   = (state_q == StResp);

  assign cmd_ready = (state_q == StIdle);
  assign accept    = cmd_valid & cmd_ready;
  assign cmd_d     = '{op: cmd_op, rd: cmd_rd, rs: cmd_rs, rt: cmd_rt, imm: cmd_imm};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) state_q <= (cmd_op == OP_LOAD) ? StWrite : StReadA;
        end
        StReadA: begin
          case (cmd_q.op)
            OP_ADD:  state_q <= StReadB;
            OP_MOV:  state_q <= StWrite;
            OP_READ: state_q <= StResp;
            default: state_q <= StIdle;
          endcase
        end
        StReadB: state_q <= StWrite;
        StWrite: state_q <= StIdle;
        StResp:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  rfc_state_reg #(.Width($bits(cmd_t))) u_cmd (
    .clk(clk), .reset(reset), .load(accept), .d(cmd_d), .q(cmd_q)
  );

  rfc_state_reg #(.Width(16)) u_a (
    .clk(clk), .reset(reset), .load(in_read_a), .d(rf_data_out), .q(a_q)
  );

  rfc_state_reg #(.Width(16)) u_b (
    .clk(clk), .reset(reset), .load(in_read_b), .d(rf_data_out), .q(b_q)
  );

  always_comb begin
    case (cmd_q.op)
      OP_LOAD: wr_data = cmd_q.imm;
      OP_MOV:  wr_data = a_q;
      OP_ADD:  wr_data = a_q + b_q;
      default: wr_data = a_q;
    endcase
  end

  // Each port shows its live value in its own state and the last one otherwise.
  always_comb begin
    rf_readnum = readnum_q;
    if (in_read_a) begin
      rf_readnum = cmd_q.rs;
    end else if (in_read_b) begin
      rf_readnum = cmd_q.rt;
    end
  end

  assign rf_write    = in_write;
  assign rf_writenum = in_write ? cmd_q.rd : wr_hold_q[18:16];
  assign rf_data_in  = in_write ? wr_data : wr_hold_q[15:0];
  assign rsp_valid   = in_resp;
  assign rsp_data    = in_resp ? a_q : rsp_q;
  assign done        = in_write | in_resp;

  rfc_state_reg #(.Width(3)) u_readnum_hold (
    .clk(clk), .reset(reset), .load(in_read_a | in_read_b), .d(rf_readnum), .q(readnum_q)
  );

  rfc_state_reg #(.Width(19)) u_wr_hold (
    .clk(clk), .reset(reset), .load(in_write), .d({rf_writenum, rf_data_in}), .q(wr_hold_q)
  );

  rfc_state_reg #(.Width(16)) u_rsp_hold (
    .clk(clk), .reset(reset), .load(in_resp), .d(a_q), .q(rsp_q)
  );

endmodule

// File: tb/tb_regfile_ctrl.sv
// Bench for regfile_ctrl driving a behavioural 8x16 register file.
// A per-command cycle schedule model is checked against the DUT on every negedge.
module tb_regfile_ctrl;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_MOV  = 2'b01;
  localparam logic [1:0] OP_ADD  = 2'b10;
  localparam logic [1:0] OP_READ = 2'b11;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = '0;
  logic [2:0]  cmd_rd = '0, cmd_rs = '0, cmd_rt = '0;
  logic [15:0] cmd_imm = '0;
  logic [2:0]  rf_readnum, rf_writenum;
  logic [15:0] rf_data_out, rf_data_in;
  logic        rf_write, rsp_valid, done;
  logic [15:0] rsp_data;

  int checks = 0;
  int failures = 0;
  int acc_count = 0;
  int done_count = 0;

  logic [15:0] mem [8];
  logic [15:0] model_reg [8];

  typedef struct {
    bit          rd_v;
    logic [2:0]  rnum;
    bit          wr;
    logic [2:0]  wnum;
    logic [15:0] wdata;
    bit          rsp;
    logic [15:0] rdata;
    bit          dn;
  } exp_t;

  exp_t exp_q[$];
  logic [2:0]  last_rnum = '0, last_wnum = '0;
  logic [15:0] last_wdata = '0, last_rsp = '0;

  regfile_ctrl dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_rs(cmd_rs), .cmd_rt(cmd_rt), .cmd_imm(cmd_imm),
    .rf_readnum(rf_readnum), .rf_data_out(rf_data_out), .rf_writenum(rf_writenum),
    .rf_write(rf_write), .rf_data_in(rf_data_in), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .done(done)
  );

  always #5 clk = ~clk;

  // Stand-in for regfile: combinational read, write on the rising edge.
  assign rf_data_out = mem[rf_readnum];
  always @(posedge clk) if (rf_write) mem[rf_writenum] <= rf_data_in;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // On acceptance, schedule the cycles the command must produce.
  always @(posedge clk) begin
    if (!reset && cmd_valid && cmd_ready) begin
      exp_t e0, e1, e2;
      e0 = '{default: 0};
      e1 = '{default: 0};
      e2 = '{default: 0};
      acc_count++;
      case (cmd_op)
        OP_LOAD: begin
          e0.wr = 1; e0.wnum = cmd_rd; e0.wdata = cmd_imm; e0.dn = 1;
          exp_q.push_back(e0);
        end
        OP_MOV: begin
          e0.rd_v = 1; e0.rnum = cmd_rs;
          e1.wr = 1; e1.wnum = cmd_rd; e1.wdata = model_reg[cmd_rs]; e1.dn = 1;
          exp_q.push_back(e0); exp_q.push_back(e1);
        end
        OP_ADD: begin
          e0.rd_v = 1; e0.rnum = cmd_rs;
          e1.rd_v = 1; e1.rnum = cmd_rt;
          e2.wr = 1; e2.wnum = cmd_rd; e2.dn = 1;
          e2.wdata = 16'((32'(model_reg[cmd_rs]) + 32'(model_reg[cmd_rt])) % 32'h10000);
          exp_q.push_back(e0); exp_q.push_back(e1); exp_q.push_back(e2);
        end
        default: begin
          e0.rd_v = 1; e0.rnum = cmd_rs;
          e1.rsp = 1; e1.rdata = model_reg[cmd_rs]; e1.dn = 1;
          exp_q.push_back(e0); exp_q.push_back(e1);
        end
      endcase
    end
    if (done) done_count++;
  end

  always @(negedge clk) begin
    exp_t e;
    bit busy;
    if (reset) begin
      exp_q.delete();
      last_rnum = '0; last_wnum = '0; last_wdata = '0; last_rsp = '0;
      e = '{default: 0};
      busy = 0;
    end else if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      busy = 1;
      if (e.rd_v) last_rnum = e.rnum;
      if (e.wr) begin
        last_wnum = e.wnum; last_wdata = e.wdata; model_reg[e.wnum] = e.wdata;
      end
      if (e.rsp) last_rsp = e.rdata;
    end else begin
      e = '{default: 0};
      busy = 0;
    end
    chk("cmd_ready", 32'(cmd_ready), 32'(!busy));
    chk("rf_write", 32'(rf_write), 32'(e.wr));
    chk("done", 32'(done), 32'(e.dn));
    chk("rsp_valid", 32'(rsp_valid), 32'(e.rsp));
    chk("rf_readnum", 32'(rf_readnum), 32'(last_rnum));
    chk("rf_writenum", 32'(rf_writenum), 32'(last_wnum));
    chk("rf_data_in", 32'(rf_data_in), 32'(last_wdata));
    chk("rsp_data", 32'(rsp_data), 32'(last_rsp));
  end

  task automatic send(input logic [1:0] op, input logic [2:0] rd, input logic [2:0] rs,
                      input logic [2:0] rt, input logic [15:0] imm, input bit hold);
    int n;
    n = acc_count;
    cmd_op = op; cmd_rd = rd; cmd_rs = rs; cmd_rt = rt; cmd_imm = imm;
    cmd_valid = 1'b1;
    for (int i = 0; i < 20 && acc_count == n; i++) begin
      @(posedge clk); #1;
    end
    if (acc_count == n) chk("accept_timeout", 32'(acc_count), 32'(n + 1));
    if (!hold) cmd_valid = 1'b0;
  endtask

  task automatic expect_read(input logic [2:0] r, input logic [15:0] val);
    bit seen;
    seen = 0;
    send(OP_READ, 3'd0, r, 3'd0, 16'h0, 1'b0);
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        seen = 1;
        chk("read_value", 32'(rsp_data), 32'(val));
      end
    end
    if (!seen) chk("rsp_timeout", 32'(seen), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int d0;
    for (int i = 0; i < 8; i++) begin
      mem[i] = '0;
      model_reg[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    idle(1);

    send(OP_LOAD, 3'd3, 3'd0, 3'd0, 16'h1234, 1'b0);
    expect_read(3'd3, 16'h1234);

    send(OP_LOAD, 3'd1, 3'd0, 3'd0, 16'h0005, 1'b0);
    send(OP_LOAD, 3'd2, 3'd0, 3'd0, 16'h0007, 1'b0);
    send(OP_ADD, 3'd4, 3'd1, 3'd2, 16'h0, 1'b0);
    expect_read(3'd4, 16'h000C);

    send(OP_LOAD, 3'd0, 3'd0, 3'd0, 16'hFFFF, 1'b0);
    send(OP_LOAD, 3'd5, 3'd0, 3'd0, 16'h0002, 1'b0);
    send(OP_ADD, 3'd6, 3'd0, 3'd5, 16'h0, 1'b0);
    expect_read(3'd6, 16'h0001);
    send(OP_ADD, 3'd6, 3'd6, 3'd6, 16'h0, 1'b0);
    expect_read(3'd6, 16'h0002);

    // Valid held high across three MOVs.
    idle(1);
    d0 = done_count;
    send(OP_MOV, 3'd7, 3'd3, 3'd0, 16'h0, 1'b1);
    send(OP_MOV, 3'd1, 3'd7, 3'd0, 16'h0, 1'b1);
    send(OP_MOV, 3'd2, 3'd1, 3'd0, 16'h0, 1'b0);
    idle(4);
    chk("mov_done_count", 32'(done_count - d0), 32'd3);
    expect_read(3'd2, 16'h1234);

    // Reset during the WRITE cycle of a LOAD.
    send(OP_LOAD, 3'd2, 3'd0, 3'd0, 16'hBEEF, 1'b0);
    reset = 1'b1;
    #1 chk("reset_kills_write", 32'(rf_write), 32'd0);
    idle(2);
    reset = 1'b0;
    #1 chk("ready_after_reset", 32'(cmd_ready), 32'd1);
    idle(1);
    expect_read(3'd2, 16'h1234);

    for (int n = 0; n < 8; n++) send(OP_LOAD, 3'(n), 3'd0, 3'd0, 16'h1000 + 16'(n), 1'b0);
    for (int n = 0; n < 8; n++) expect_read(3'(n), 16'h1000 + 16'(n));

    for (int k = 0; k < 300; k++) begin
      int gap;
      gap = int'($urandom_range(0, 2));
      send(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
           3'($urandom_range(0, 7)), 16'($urandom), gap == 0);
      if (gap > 0) begin
        cmd_valid = 1'b0;
        idle(gap);
      end
    end
    cmd_valid = 1'b0;
    idle(6);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
